// File: rtl/lsu_bus_ctrl.sv
// Load/store engine: turns decode-stage mem commands into single-beat req/gnt/rvalid bus transactions.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
module lsu_bus_ctrl #(
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [2:0]    mem_op,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          lsu_stall,
    output logic          lsu_done,
    output logic          lsu_err,
    output logic [31:0]   lsu_rdata,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_be,
    output logic [31:0]   bus_wdata,
    input  logic          bus_gnt,
    input  logic          bus_rvalid,
    input  logic [31:0]   bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_r;
    logic [2:0]  op_r;
    logic [1:0]  off_r;

    logic        accept_s;
    logic        op_ok_s;
    logic        align_ok_s;
    logic        err_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] lane_s;
    logic [31:0] ext_s;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_r;
    logic          timeout_s;
    assign timeout_s = (cnt_r == CW'(TIMEOUT_CYCLES - 1));
`endif

    // Reset is folded in so no stall is reported while the block is held in reset.
    assign accept_s  = rst_n & (state_r == IDLE) & req_valid & (mem_rd | mem_wr);
    assign lsu_stall = accept_s | (state_r == REQ) | (state_r == WAIT_R);

    // Command legality, byte enables and lane-replicated store data.
    always_comb begin
        op_ok_s    = 1'b0;
        align_ok_s = 1'b1;
        be_s       = 4'b1111;
        wdata_s    = wdata;
        case (mem_op)
            3'b000, 3'b001, 3'b010: op_ok_s = 1'b1;
            3'b100, 3'b101:         op_ok_s = ~mem_wr;
            default:                op_ok_s = 1'b0;
        endcase
        case (mem_op[1:0])
            2'b00: begin
                be_s    = 4'b0001 << addr[1:0];
                wdata_s = {4{wdata[7:0]}};
            end
            2'b01: begin
                align_ok_s = ~addr[0];
                be_s       = 4'b0011 << addr[1:0];
                wdata_s    = {2{wdata[15:0]}};
            end
            default: begin
                align_ok_s = (addr[1:0] == 2'b00);
                be_s       = 4'b1111;
                wdata_s    = wdata;
            end
        endcase
        err_s = (mem_rd & mem_wr) | ~op_ok_s | ~align_ok_s;
    end

    // Load lane select and sign/zero extension of the returned word.
    always_comb begin
        lane_s = bus_rdata >> {off_r, 3'b000};
        case (op_r)
            3'b000:  ext_s = {{24{lane_s[7]}}, lane_s[7:0]};
            3'b100:  ext_s = {24'h00_0000, lane_s[7:0]};
            3'b001:  ext_s = {{16{lane_s[15]}}, lane_s[15:0]};
            3'b101:  ext_s = {16'h0000, lane_s[15:0]};
            default: ext_s = lane_s;
        endcase
    end

    // Transaction FSM with all bus and completion outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            op_r      <= 3'b000;
            off_r     <= 2'b00;
            lsu_done  <= 1'b0;
            lsu_err   <= 1'b0;
            lsu_rdata <= 32'h0000_0000;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0000_0000;
`ifdef LSU_TIMEOUT_EN
            cnt_r     <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    lsu_done <= 1'b0;
                    lsu_err  <= 1'b0;
                    if (accept_s) begin
                        op_r  <= mem_op;
                        off_r <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
                        cnt_r <= '0;
`endif
                        if (err_s) begin
                            state_r  <= DONE;
                            lsu_done <= 1'b1;
                            lsu_err  <= 1'b1;
                        end else begin
                            state_r   <= REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_wr;
                            bus_addr  <= {addr[AW-1:2], 2'b00};
                            bus_be    <= be_s;
                            bus_wdata <= wdata_s;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        if (bus_we) begin
                            state_r  <= DONE;
                            lsu_done <= 1'b1;
                        end else begin
                            state_r <= WAIT_R;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (timeout_s) begin
                        bus_req  <= 1'b0;
                        state_r  <= DONE;
                        lsu_done <= 1'b1;
                        lsu_err  <= 1'b1;
                    end
`endif
                    else begin
                        state_r <= REQ;
                    end
`ifdef LSU_TIMEOUT_EN
                    cnt_r <= cnt_r + CW'(1);
`endif
                end
                WAIT_R: begin
                    if (bus_rvalid) begin
                        lsu_rdata <= ext_s;
                        state_r   <= DONE;
                        lsu_done  <= 1'b1;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (timeout_s) begin
                        state_r  <= DONE;
                        lsu_done <= 1'b1;
                        lsu_err  <= 1'b1;
                    end
`endif
                    else begin
                        state_r <= WAIT_R;
                    end
`ifdef LSU_TIMEOUT_EN
                    cnt_r <= cnt_r + CW'(1);
`endif
                end
                DONE: begin
                    lsu_done <= 1'b0;
                    lsu_err  <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    lsu_done <= 1'b0;
                    lsu_err  <= 1'b0;
                    bus_req  <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule
